// File: rtl/serial_to_parallel_sync.sv
// Serial-to-parallel receiver: slides over the bit stream for a comma symbol,
// confirms byte alignment with consecutive commas, then emits aligned bytes.
module serial_to_parallel_sync #(
  parameter logic [7:0]  COM        = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned COM_CNT_W = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t                 r_state;
  logic [BYTE_W-1:0]      r_sr;
  logic [CNT_W-1:0]       r_cnt;
  logic [COM_CNT_W-1:0]   r_com_cnt;
  logic [BYTE_W-1:0]      r_data_out;
  logic                   r_valid_out;
  logic                   r_byte_strobe;
  logic                   r_active;

  logic [BYTE_W-1:0]      w_nxt;
  logic                   w_is_com;
  logic                   w_boundary;
  logic [COM_CNT_W-1:0]   w_com_cnt_inc;

  // Candidate byte includes the bit arriving on this edge.
  assign w_nxt         = {r_sr[BYTE_W-2:0], data_in};
  assign w_is_com      = (w_nxt == COM);
  assign w_boundary    = (r_cnt == CNT_W'(BYTE_W - 1));
  assign w_com_cnt_inc = r_com_cnt + COM_CNT_W'(1);

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      r_sr <= '0;
    end else begin
      r_sr <= w_nxt;
    end
  end

  // Alignment FSM with registered byte outputs.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      r_state       <= SEARCH;
      r_cnt         <= '0;
      r_com_cnt     <= '0;
      r_data_out    <= '0;
      r_valid_out   <= 1'b0;
      r_byte_strobe <= 1'b0;
      r_active      <= 1'b0;
    end else begin
      r_byte_strobe <= 1'b0;
      if (r_state != SEARCH) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      case (r_state)
        SEARCH: begin
          if (w_is_com) begin
            r_cnt     <= '0;
            r_com_cnt <= COM_CNT_W'(1);
            if (LOCK_COUNT == 1) begin
              r_state  <= ACTIVE;
              r_active <= 1'b1;
            end else begin
              r_state  <= ALIGN;
            end
          end
        end
        ALIGN: begin
          if (w_boundary) begin
            if (w_is_com) begin
              r_com_cnt <= w_com_cnt_inc;
              if (w_com_cnt_inc == COM_CNT_W'(LOCK_COUNT)) begin
                r_state  <= ACTIVE;
                r_active <= 1'b1;
              end
            end else begin
              // A misaligned comma lands here too; alignment restarts from scratch.
              r_state   <= SEARCH;
              r_com_cnt <= '0;
            end
          end
        end
        ACTIVE: begin
          if (w_boundary) begin
            r_data_out    <= w_nxt;
            r_valid_out   <= !w_is_com;
            r_byte_strobe <= 1'b1;
          end
        end
        default: begin
          r_state <= SEARCH;
        end
      endcase
    end
  end

  assign data_out    = r_data_out;
  assign valid_out   = r_valid_out;
  assign byte_strobe = r_byte_strobe;
  assign active      = r_active;

endmodule

// File: doc/serial_to_parallel_sync.md
SERIAL_TO_PARALLEL_SYNC -- requirements
Module: serial_to_parallel_sync

Interface
REQ-001 SHALL have port clk_32f  input  1  the single bit-rate clock; every register samples on its rising edge.
REQ-002 SHALL have port reset_L  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port data_in  input  1  serial line, MSB of each byte first, one bit per clk_32f.
REQ-004 SHALL have port data_out  output  8  last assembled byte.
REQ-005 SHALL have port valid_out  output  1  data_out is a payload byte for the downstream 8-to-32 demux.
REQ-006 SHALL have port byte_strobe  output  1  one-cycle pulse marking each new byte on data_out.
REQ-007 SHALL have port active  output  1  receiver is in ACTIVE, i.e. byte alignment is locked.
REQ-008 SHALL have parameter COM, default 8'hBC, meaning the comma/idle symbol used for alignment.
REQ-009 SHALL have parameter LOCK_COUNT, default 4, meaning the number of consecutive aligned COM bytes needed to enter ACTIVE (legal range 1..15).

Function
REQ-010 SHALL shift data_in into an 8-bit shift register sr on every clk_32f edge: sr <= {sr[6:0], data_in}.
REQ-011 SHALL form the candidate byte as nxt = {sr[6:0], data_in}.
REQ-012 SHALL implement a 3-state FSM: SEARCH, ALIGN, ACTIVE.
REQ-013 SEARCH: SHALL compare nxt with COM on every edge (sliding window); on a match, SHALL go to ALIGN, set bit counter cnt = 0 and com_cnt = 1.
REQ-014 Outside SEARCH, cnt SHALL increment modulo 8 each edge, and a byte boundary SHALL occur on each edge where cnt == 7.
REQ-015 ALIGN, at a byte boundary with nxt == COM: SHALL increment com_cnt; when com_cnt reaches LOCK_COUNT, SHALL go to ACTIVE.
REQ-016 ALIGN, at a byte boundary with nxt != COM: SHALL return to SEARCH and clear com_cnt.
REQ-017 With LOCK_COUNT == 1, the COM match in SEARCH SHALL go directly to ACTIVE, with cnt = 0.
REQ-018 ACTIVE: SHALL stay in ACTIVE until reset, with no loss-of-sync detection.
REQ-019 ACTIVE, at every byte boundary: SHALL load data_out <= nxt, assert byte_strobe for the next cycle only, and set valid_out <= (nxt != COM).
REQ-020 valid_out SHALL hold its value between byte boundaries, i.e. for 8 cycles.
REQ-021 In SEARCH and ALIGN: data_out SHALL hold 8'h00, valid_out SHALL be 0 and byte_strobe SHALL be 0.
REQ-022 active SHALL be 1 exactly while the FSM is in ACTIVE.
REQ-023 Latency: the LSB of a byte is sampled on edge E; the byte appears on data_out/valid_out after edge E; byte_strobe is high from E to E+1.
REQ-024 A COM byte split across a false boundary in ALIGN SHALL count as a non-COM byte (REQ-016); the FSM does not re-slide.

Reset
REQ-025 While reset_L = 0, SHALL asynchronously force: state = SEARCH, sr = 0, cnt = 0, com_cnt = 0, data_out = 8'h00, valid_out = 0, byte_strobe = 0, active = 0.
REQ-026 Reset asserted mid-byte or in ACTIVE SHALL discard all partial data; after release the FSM SHALL re-acquire from SEARCH.
REQ-027 The first edge after reset_L rises SHALL be treated as a normal shift edge.

Verification
REQ-028 Scenario: reset, then 4x 8'hBC MSB-first, then 8'hEE, 8'hFF -> active rises after the 4th BC's last bit; data_out = EE with valid_out = 1, then FF with valid_out = 1; byte_strobe pulses once per byte, 8 cycles apart.
REQ-029 Scenario: 3 random bits, then 4x BC, then 8'hFD -> alignment at the bit offset of the first BC; data_out = FD, valid_out = 1.
REQ-030 Scenario: BC, BC, 8'h12, then 4x BC, then 8'hCC -> returns to SEARCH at 12 with active = 0; locks on the later BCs; then data_out = CC.
REQ-031 Scenario: in ACTIVE, BC, AA, BC -> data_out = BC (valid_out = 0), AA (valid_out = 1), BC (valid_out = 0); active stays 1.
REQ-032 Scenario: reset_L pulsed low mid-byte in ACTIVE -> all outputs immediately 0, no clock edge needed; re-lock requires 4 new BCs.
REQ-033 Scenario: LOCK_COUNT = 1 with a single BC then 8'hAA -> active after the BC; data_out = AA at the next boundary.
